// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: data port has priority,
// fetch is protected from starvation, and read responses are routed by a latency-matched
// owner queue. Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_starve,
`endif
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic {DPRIO, IPRIO} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MEM_LATENCY-1:0] vld_q, own_q;
  logic                   rd_issue;

  // Same-cycle grant; both grants are forced low while reset is asserted
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (i_req && d_req) begin
        if (state_q == IPRIO) i_gnt = 1'b1;
        else                  d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory request mux; idle bus is driven to zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end
  end

  assign rd_issue = mem_en && (mem_we == 4'b0000);

  // Starvation counter and priority state next-state logic
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (i_req && !i_gnt) begin
      cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    case (state_q)
      DPRIO: begin
        if ((STARVE_MAX > 0) && (cnt_q == CNT_W'(STARVE_MAX)) && i_req && !i_gnt) begin
          state_d = IPRIO;
        end
      end
      IPRIO: begin
        if (i_gnt) state_d = DPRIO;
      end
      default: state_d = DPRIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DPRIO;
      cnt_q   <= '0;
      vld_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q[0] <= rd_issue;
      own_q[0] <= d_gnt;
      for (int k = 1; k < int'(MEM_LATENCY); k++) begin
        vld_q[k] <= vld_q[k-1];
        own_q[k] <= own_q[k-1];
      end
    end
  end

  assign d_rvalid = vld_q[MEM_LATENCY-1] &  own_q[MEM_LATENCY-1];
  assign i_rvalid = vld_q[MEM_LATENCY-1] & ~own_q[MEM_LATENCY-1];
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_starve_q;

  // Conflict cycles and starvation escalations, free-running and wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_conflict_q <= 32'h0;
      perf_starve_q   <= 32'h0;
    end else begin
      if (i_req && d_req) perf_conflict_q <= perf_conflict_q + 32'd1;
      if ((state_q == DPRIO) && (state_d == IPRIO)) perf_starve_q <= perf_starve_q + 32'd1;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_starve   = perf_starve_q;
`endif

endmodule
